// File: rtl/memory_layer_memory.sv
// GAM memory layer entry store addressed by (class, node): prototype X, weight W, tag, Th, M.
// Optional hit_o output (registered valid-and-in-range flag on READ) enabled by macro GAM_MEM_HIT_EN.
module memory_layer_memory #(
  parameter int NUM_CLASSES = 8,
  parameter int NUM_NODES   = 64,
  parameter int VECTOR_LEN  = 4,
  parameter int ELEM_W      = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic signed [31:0]             class_i,
  input  logic signed [31:0]             node_i,
  input  logic signed [31:0]             Th_i,
  input  logic signed [31:0]             M_i,
  input  logic                           X_c,
  input  logic                           W_c,
  input  logic                           C_c,
  input  logic                           T_c,
  input  logic                           M_c,
  input  logic                           RD_WR_c,
  input  logic [VECTOR_LEN*ELEM_W-1:0]   X_i,
  input  logic [VECTOR_LEN*ELEM_W-1:0]   W_i,
  output logic signed [31:0]             class_o,
  output logic signed [31:0]             node_o,
  output logic signed [31:0]             Th_o,
  output logic signed [31:0]             M_o,
  output logic [VECTOR_LEN*ELEM_W-1:0]   X_o,
  output logic [VECTOR_LEN*ELEM_W-1:0]   W_o
`ifdef GAM_MEM_HIT_EN
  ,
  output logic                           hit_o
`endif
);

  localparam int VEC_W = VECTOR_LEN * ELEM_W;
  localparam int DEPTH = NUM_CLASSES * NUM_NODES;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [VEC_W-1:0]   r_x_mem    [DEPTH];
  logic [VEC_W-1:0]   r_w_mem    [DEPTH];
  logic signed [31:0] r_cls_mem  [DEPTH];
  logic signed [31:0] r_node_mem [DEPTH];
  logic signed [31:0] r_th_mem   [DEPTH];
  logic signed [31:0] r_m_mem    [DEPTH];
  logic [DEPTH-1:0]   r_valid;

  logic               w_in_range;
  logic               w_any_sel;
  logic               w_wr;
  logic               w_rd_hit;
  logic               w_new;
  logic [IDX_W-1:0]   w_idx;

  assign w_in_range = (class_i >= 0) && (class_i < NUM_CLASSES) &&
                      (node_i >= 0) && (node_i < NUM_NODES);
  assign w_idx      = IDX_W'($unsigned(class_i)) * IDX_W'(NUM_NODES) + IDX_W'($unsigned(node_i));
  assign w_any_sel  = X_c | W_c | C_c | T_c | M_c;
  assign w_wr       = RD_WR_c && w_in_range && w_any_sel;
  assign w_rd_hit   = w_in_range && r_valid[w_idx];
  assign w_new      = !r_valid[w_idx];

  // Valid bits: cleared by reset, so a write racing reset leaves its entry invalid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else if (w_wr) begin
      r_valid[w_idx] <= 1'b1;
    end
  end

  // Entry storage: the first write to an invalid entry zeroes its unselected fields so
  // every field of a valid entry is defined and matches what an invalid entry reads as.
  always_ff @(posedge clk) begin
    if (!rst && w_wr) begin
      if (X_c || w_new) r_x_mem[w_idx] <= X_c ? X_i : '0;
      if (W_c || w_new) r_w_mem[w_idx] <= W_c ? W_i : '0;
      if (C_c || w_new) begin
        r_cls_mem[w_idx]  <= C_c ? class_i : '0;
        r_node_mem[w_idx] <= C_c ? node_i : '0;
      end
      if (T_c || w_new) r_th_mem[w_idx] <= T_c ? Th_i : '0;
      if (M_c || w_new) r_m_mem[w_idx]  <= M_c ? M_i : '0;
    end
  end

  // Read stage: registered outputs, held through WRITE cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      class_o <= '0;
      node_o  <= '0;
      Th_o    <= '0;
      M_o     <= '0;
      X_o     <= '0;
      W_o     <= '0;
    end else if (!RD_WR_c) begin
      if (w_rd_hit) begin
        class_o <= r_cls_mem[w_idx];
        node_o  <= r_node_mem[w_idx];
        Th_o    <= r_th_mem[w_idx];
        M_o     <= r_m_mem[w_idx];
        X_o     <= r_x_mem[w_idx];
        W_o     <= r_w_mem[w_idx];
      end else begin
        class_o <= '0;
        node_o  <= '0;
        Th_o    <= '0;
        M_o     <= '0;
        X_o     <= '0;
        W_o     <= '0;
      end
    end
  end

`ifdef GAM_MEM_HIT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_o <= 1'b0;
    end else if (!RD_WR_c) begin
      hit_o <= w_rd_hit;
    end
  end
`endif

endmodule

// File: tb/tb_memory_layer_memory.sv
// Directed self-checking bench for memory_layer_memory (hit_o checks only when GAM_MEM_HIT_EN is defined).
module tb_memory_layer_memory;

  logic               clk;
  logic               rst;
  logic signed [31:0] class_i, node_i, Th_i, M_i;
  logic               X_c, W_c, C_c, T_c, M_c, RD_WR_c;
  logic [31:0]        X_i, W_i;
  logic signed [31:0] class_o, node_o, Th_o, M_o;
  logic [31:0]        X_o, W_o;
`ifdef GAM_MEM_HIT_EN
  logic               hit_o;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  memory_layer_memory dut (
    .clk     (clk),
    .rst     (rst),
    .class_i (class_i),
    .node_i  (node_i),
    .Th_i    (Th_i),
    .M_i     (M_i),
    .X_c     (X_c),
    .W_c     (W_c),
    .C_c     (C_c),
    .T_c     (T_c),
    .M_c     (M_c),
    .RD_WR_c (RD_WR_c),
    .X_i     (X_i),
    .W_i     (W_i),
    .class_o (class_o),
    .node_o  (node_o),
    .Th_o    (Th_o),
    .M_o     (M_o),
    .X_o     (X_o),
    .W_o     (W_o)
`ifdef GAM_MEM_HIT_EN
    ,
    .hit_o   (hit_o)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required=<200000", $time);
    $fatal(1, "watchdog");
  end

  // Drive one operation and step to 1 time unit after the sampling edge.
  task automatic op(input logic wr, input int cls, input int nd,
                    input logic [4:0] sel, input logic [31:0] x, input logic [31:0] w,
                    input int th, input int m);
    RD_WR_c = wr;
    class_i = cls;
    node_i  = nd;
    {X_c, W_c, C_c, T_c, M_c} = sel;
    X_i = x;
    W_i = w;
    Th_i = th;
    M_i = m;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [191:0] got;
    rst = 1'b1;
    op(1'b0, 0, 0, 5'b0, 32'h0, 32'h0, 0, 0);
    #1;
    got = {class_o, node_o, Th_o, M_o, X_o, W_o};
    n_cmp++;
    if (got !== 192'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0", got);
    end
`ifdef GAM_MEM_HIT_EN
    n_cmp++;
    if (hit_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hit: got %b required 0", hit_o);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_unwritten;
    logic [191:0] got;
    op(1'b0, 0, 0, 5'b11111, 32'hDEAD_BEEF, 32'h1234_5678, 9, 9);
    got = {class_o, node_o, Th_o, M_o, X_o, W_o};
    n_cmp++;
    if (got !== 192'h0) begin
      n_fail++;
      $display("FAIL unwritten_read_0_0: got %h required 0", got);
    end
`ifdef GAM_MEM_HIT_EN
    n_cmp++;
    if (hit_o !== 1'b0) begin
      n_fail++;
      $display("FAIL unwritten_hit: got %b required 0", hit_o);
    end
`endif
    op(1'b1, 8, 0, 5'b11111, 32'hAAAA_5555, 32'h5555_AAAA, 3, 4);
    op(1'b0, 8, 0, 5'b0, 32'h0, 32'h0, 0, 0);
    got = {class_o, node_o, Th_o, M_o, X_o, W_o};
    n_cmp++;
    if (got !== 192'h0) begin
      n_fail++;
      $display("FAIL oor_read_8_0: got %h required 0", got);
    end
`ifdef GAM_MEM_HIT_EN
    n_cmp++;
    if (hit_o !== 1'b0) begin
      n_fail++;
      $display("FAIL oor_hit: got %b required 0", hit_o);
    end
`endif
    op(1'b1, 0, -1, 5'b11111, 32'h1, 32'h1, 1, 1);
    op(1'b0, 0, 0, 5'b0, 32'h0, 32'h0, 0, 0);
    got = {class_o, node_o, Th_o, M_o, X_o, W_o};
    n_cmp++;
    if (got !== 192'h0) begin
      n_fail++;
      $display("FAIL oor_no_alias_0_0: got %h required 0", got);
    end
  endtask

  task automatic test_tag_scalar;
    logic [191:0] got, exp;
    op(1'b1, 4, 49, 5'b00111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1);
    op(1'b0, 4, 49, 5'b0, 32'h0, 32'h0, 0, 0);
    got = {class_o, node_o, Th_o, M_o, X_o, W_o};
    exp = {32'd4, 32'd49, 32'd1, 32'd1, 32'h0, 32'h0};
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL tag_scalar_read: got %h required %h", got, exp);
    end
`ifdef GAM_MEM_HIT_EN
    n_cmp++;
    if (hit_o !== 1'b1) begin
      n_fail++;
      $display("FAIL tag_scalar_hit: got %b required 1", hit_o);
    end
`endif
  endtask

  task automatic test_vectors;
    logic [191:0] got, exp;
    op(1'b1, 2, 1, 5'b11000, 32'h0000_0001, 32'h0000_0002, 5, 5);
    op(1'b1, 1, 3, 5'b11000, 32'h0000_0000, 32'h0000_0001, 6, 6);
    op(1'b0, 1, 3, 5'b0, 32'h0, 32'h0, 0, 0);
    got = {class_o, node_o, Th_o, M_o, X_o, W_o};
    exp = {32'd0, 32'd0, 32'd0, 32'd0, 32'h0, 32'h1};
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL vec_read_1_3: got %h required %h", got, exp);
    end
    op(1'b0, 2, 1, 5'b0, 32'h0, 32'h0, 0, 0);
    got = {class_o, node_o, Th_o, M_o, X_o, W_o};
    exp = {32'd0, 32'd0, 32'd0, 32'd0, 32'h1, 32'h2};
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL vec_read_2_1: got %h required %h", got, exp);
    end
  endtask

  task automatic test_hold;
    logic [191:0] got, exp;
    op(1'b0, 2, 1, 5'b0, 32'h0, 32'h0, 0, 0);
    op(1'b1, 6, 6, 5'b11111, 32'h7777_7777, 32'h8888_8888, 66, 66);
    got = {class_o, node_o, Th_o, M_o, X_o, W_o};
    exp = {32'd0, 32'd0, 32'd0, 32'd0, 32'h1, 32'h2};
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL hold_during_write: got %h required %h", got, exp);
    end
    op(1'b0, 6, 6, 5'b0, 32'h0, 32'h0, 0, 0);
    got = {class_o, node_o, Th_o, M_o, X_o, W_o};
    exp = {32'd6, 32'd6, 32'd66, 32'd66, 32'h7777_7777, 32'h8888_8888};
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL full_write_read_6_6: got %h required %h", got, exp);
    end
  endtask

  task automatic test_partial;
    logic [191:0] got, exp;
    op(1'b1, 1, 2, 5'b10000, 32'h0F0F_0F0F, 32'h1111_1111, 2, 2);
    op(1'b1, 1, 2, 5'b01000, 32'h2222_2222, 32'hFFFF_FFFF, 3, 3);
    op(1'b0, 1, 2, 5'b11111, 32'h0, 32'h0, 0, 0);
    got = {class_o, node_o, Th_o, M_o, X_o, W_o};
    exp = {32'd0, 32'd0, 32'd0, 32'd0, 32'h0F0F_0F0F, 32'hFFFF_FFFF};
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL partial_update_1_2: got %h required %h", got, exp);
    end
    op(1'b1, 1, 2, 5'b00010, 32'h0, 32'h0, -5, 0);
    op(1'b0, 1, 2, 5'b0, 32'h0, 32'h0, 0, 0);
    got = {class_o, node_o, Th_o, M_o, X_o, W_o};
    exp = {32'd0, 32'd0, 32'hFFFF_FFFB, 32'd0, 32'h0F0F_0F0F, 32'hFFFF_FFFF};
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL partial_th_only_1_2: got %h required %h", got, exp);
    end
  endtask

  task automatic test_no_select;
    logic [191:0] got;
    op(1'b1, 5, 5, 5'b00000, 32'h1234_5678, 32'h8765_4321, 9, 9);
    op(1'b0, 5, 5, 5'b0, 32'h0, 32'h0, 0, 0);
    got = {class_o, node_o, Th_o, M_o, X_o, W_o};
    n_cmp++;
    if (got !== 192'h0) begin
      n_fail++;
      $display("FAIL no_select_write_5_5: got %h required 0", got);
    end
  endtask

  task automatic test_reset_mid;
    logic [191:0] got;
    op(1'b0, 4, 49, 5'b0, 32'h0, 32'h0, 0, 0);
    RD_WR_c = 1'b1;
    class_i = 3;
    node_i  = 5;
    {X_c, W_c, C_c, T_c, M_c} = 5'b00010;
    Th_i = 7;
    #2;
    rst = 1'b1;
    #1;
    got = {class_o, node_o, Th_o, M_o, X_o, W_o};
    n_cmp++;
    if (got !== 192'h0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got %h required 0", got);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    op(1'b0, 3, 5, 5'b0, 32'h0, 32'h0, 0, 0);
    got = {class_o, node_o, Th_o, M_o, X_o, W_o};
    n_cmp++;
    if (got !== 192'h0) begin
      n_fail++;
      $display("FAIL reset_mid_read_3_5: got %h required 0", got);
    end
    op(1'b0, 4, 49, 5'b0, 32'h0, 32'h0, 0, 0);
    got = {class_o, node_o, Th_o, M_o, X_o, W_o};
    n_cmp++;
    if (got !== 192'h0) begin
      n_fail++;
      $display("FAIL reset_cleared_4_49: got %h required 0", got);
    end
`ifdef GAM_MEM_HIT_EN
    n_cmp++;
    if (hit_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_cleared_hit: got %b required 0", hit_o);
    end
`endif
  endtask

  initial begin
    rst = 1'b0;
    RD_WR_c = 1'b0;
    class_i = 0;
    node_i = 0;
    Th_i = 0;
    M_i = 0;
    {X_c, W_c, C_c, T_c, M_c} = 5'b0;
    X_i = 32'h0;
    W_i = 32'h0;
    test_reset;
    test_unwritten;
    test_tag_scalar;
    test_vectors;
    test_hold;
    test_partial;
    test_no_select;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
